// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter for the single write port (WE3/A3/WD3) of the
// register bank. It grants one writeback source per cycle and registers the
// winning write. Writes to the read-only constant registers 0 and 15 are
// consumed without a write enable and are flagged on RO_ERR.
module regbank_write_arbiter #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     FREEZE,
  input  logic [N_REQ-1:0]         REQ_VALID,
  input  logic [N_REQ*ADDR_W-1:0]  REQ_ADDR,
  input  logic [N_REQ*DATA_W-1:0]  REQ_DATA,
  output logic [N_REQ-1:0]         REQ_READY,
  output logic                     WE3,
  output logic [ADDR_W-1:0]        A3,
  output logic [DATA_W-1:0]        WD3,
  output logic                     RO_ERR,
  output logic [1:0]               LAST_GRANT
);

  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        last_q, last_d;
  logic              we_q, we_d;
  logic              ro_q, ro_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] wd_q, wd_d;

  logic              found;
  logic              fire;
  logic [1:0]        gidx;
  logic [ADDR_W-1:0] gaddr;
  logic [DATA_W-1:0] gdata;
  logic              g_is_ro;

  // Rotating priority scan starting at ptr_q; the first valid requester wins.
  always_comb begin
    int idx;
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && (idx == i) && REQ_VALID[i]) begin
          found = 1'b1;
          gidx  = 2'(i);
        end
      end
    end
  end

  // Grants are suppressed during reset and freeze; ready implies valid,
  // so a visible grant is always a handshake.
  assign fire = found && !RST && !FREEZE;

  // One-hot ready vector and selection of the winning address/data.
  always_comb begin
    REQ_READY = '0;
    gaddr     = '0;
    gdata     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gidx == 2'(i)) begin
        REQ_READY[i] = fire;
        gaddr        = REQ_ADDR[i*ADDR_W +: ADDR_W];
        gdata        = REQ_DATA[i*DATA_W +: DATA_W];
      end
    end
  end

  assign g_is_ro = (gaddr == '0) || (gaddr == ADDR_W'(15));

  // Next-state: advance the pointer past the winner and load the output stage.
  always_comb begin
    ptr_d  = ptr_q;
    last_d = last_q;
    we_d   = 1'b0;
    ro_d   = 1'b0;
    a_d    = a_q;
    wd_d   = wd_q;
    if (fire) begin
      ptr_d  = (gidx == 2'(N_REQ-1)) ? 2'd0 : gidx + 2'd1;
      last_d = gidx;
      we_d   = !g_is_ro;
      ro_d   = g_is_ro;
      a_d    = gaddr;
      wd_d   = gdata;
    end
  end

  // State registers; reset wins over any capture on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q  <= '0;
      last_q <= '0;
      we_q   <= 1'b0;
      ro_q   <= 1'b0;
      a_q    <= '0;
      wd_q   <= '0;
    end else begin
      ptr_q  <= ptr_d;
      last_q <= last_d;
      we_q   <= we_d;
      ro_q   <= ro_d;
      a_q    <= a_d;
      wd_q   <= wd_d;
    end
  end

  assign WE3        = we_q;
  assign A3         = a_q;
  assign WD3        = wd_q;
  assign RO_ERR     = ro_q;
  assign LAST_GRANT = last_q;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench for regbank_write_arbiter with two requesters and a small
// register bank model hanging off the write port.
module tb_regbank_write_arbiter;

  logic        CLK;
  logic        RST;
  logic        FREEZE;
  logic [1:0]  REQ_VALID;
  logic [7:0]  REQ_ADDR;
  logic [63:0] REQ_DATA;
  logic [1:0]  REQ_READY;
  logic        WE3;
  logic [3:0]  A3;
  logic [31:0] WD3;
  logic        RO_ERR;
  logic [1:0]  LAST_GRANT;

  int checks = 0;
  int errors = 0;

  logic [31:0] bank [16];

  regbank_write_arbiter #(.N_REQ(2), .DATA_W(32), .ADDR_W(4)) dut (
    .CLK(CLK), .RST(RST), .FREEZE(FREEZE),
    .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .REQ_READY(REQ_READY), .WE3(WE3), .A3(A3), .WD3(WD3),
    .RO_ERR(RO_ERR), .LAST_GRANT(LAST_GRANT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Bank model: registers 0 and 15 are hard-wired constants.
  always @(posedge CLK) if (WE3) bank[A3] <= WD3;

  function automatic logic [31:0] bank_rd(input int a);
    if (a == 0)  return 32'd65536;
    if (a == 15) return 32'd81928;
    return bank[a];
  endfunction

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; FREEZE = 1'b0; REQ_VALID = 2'b11;
    REQ_ADDR = {4'd2, 4'd1}; REQ_DATA = {32'h22, 32'h11};
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      checks++; if (REQ_READY !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", REQ_READY); end
      checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL reset_we3 got %b want 0", WE3); end
    end
    checks++; if ({A3, WD3, RO_ERR, LAST_GRANT} !== '0) begin errors++; $display("FAIL reset_regs got a3=%0h wd3=%0h ro=%b lg=%0d want 0", A3, WD3, RO_ERR, LAST_GRANT); end
    @(posedge CLK); #1; RST = 1'b0;
    @(negedge CLK);
    checks++; if (REQ_READY !== 2'b01) begin errors++; $display("FAIL post_reset_ready got %b want 01", REQ_READY); end
    REQ_VALID = 2'b00;
    tick();
  endtask

  task automatic test_single();
    REQ_ADDR = {4'd5, 4'd0}; REQ_DATA = {32'hAA, 32'h0}; REQ_VALID = 2'b10;
    @(negedge CLK);
    checks++; if (REQ_READY !== 2'b10) begin errors++; $display("FAIL single_ready got %b want 10", REQ_READY); end
    tick(); REQ_VALID = 2'b00;
    @(negedge CLK);
    checks++; if ({WE3, A3, WD3} !== {1'b1, 4'd5, 32'hAA}) begin errors++; $display("FAIL single_write got we=%b a3=%0d wd3=%0h want we=1 a3=5 wd3=aa", WE3, A3, WD3); end
    checks++; if (LAST_GRANT !== 2'd1 || RO_ERR !== 1'b0) begin errors++; $display("FAIL single_lg got lg=%0d ro=%b want lg=1 ro=0", LAST_GRANT, RO_ERR); end
    tick();
    @(negedge CLK);
    checks++; if (bank_rd(5) !== 32'hAA) begin errors++; $display("FAIL single_bank got %0h want aa", bank_rd(5)); end
    checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL single_we_drop got %b want 0", WE3); end
    tick();
  endtask

  task automatic test_alternate();
    logic [31:0] d0, d1, prev_wd;
    int g, prev_g, we_cnt;
    d0 = 32'h100; d1 = 32'h200; prev_wd = '0; prev_g = 0; we_cnt = 0;
    REQ_ADDR = {4'd3, 4'd2}; REQ_DATA = {d1, d0}; REQ_VALID = 2'b11;
    for (int j = 0; j <= 6; j++) begin
      g = j % 2;
      @(negedge CLK);
      if (j < 6) begin
        checks++; if (REQ_READY !== (2'b01 << g)) begin errors++; $display("FAIL alt_ready[%0d] got %b want %b", j, REQ_READY, 2'b01 << g); end
      end
      if (j > 0) begin
        if (WE3 === 1'b1) we_cnt++;
        checks++; if (WD3 !== prev_wd || LAST_GRANT !== 2'(prev_g)) begin errors++; $display("FAIL alt_out[%0d] got wd3=%0h lg=%0d want wd3=%0h lg=%0d", j, WD3, LAST_GRANT, prev_wd, prev_g); end
      end
      tick();
      if (j < 6) begin
        prev_g = g;
        if (g == 0) begin prev_wd = d0; d0 = 32'h100 + 32'(j + 1); end
        else        begin prev_wd = d1; d1 = 32'h200 + 32'(j + 1); end
        REQ_DATA = {d1, d0};
        if (j == 5) REQ_VALID = 2'b00;
      end
    end
    checks++; if (we_cnt != 6) begin errors++; $display("FAIL alt_we_count got %0d want 6", we_cnt); end
    @(negedge CLK);
    checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL alt_we_drop got %b want 0", WE3); end
    checks++; if (bank_rd(2) !== 32'h103 || bank_rd(3) !== 32'h204) begin errors++; $display("FAIL alt_bank got r2=%0h r3=%0h want 103 204", bank_rd(2), bank_rd(3)); end
    tick();
  endtask

  task automatic test_same_addr();
    // One write from req0 moves the pointer to 1.
    REQ_ADDR = {4'd0, 4'd3}; REQ_DATA = {32'h0, 32'h33}; REQ_VALID = 2'b01;
    tick(); REQ_VALID = 2'b00;
    tick();
    REQ_ADDR = {4'd7, 4'd7}; REQ_DATA = {32'h22, 32'h11}; REQ_VALID = 2'b11;
    @(negedge CLK);
    checks++; if (REQ_READY !== 2'b10) begin errors++; $display("FAIL same_first got %b want 10", REQ_READY); end
    tick(); REQ_VALID = 2'b01;
    @(negedge CLK);
    checks++; if (REQ_READY !== 2'b01) begin errors++; $display("FAIL same_second got %b want 01", REQ_READY); end
    checks++; if ({WE3, A3, WD3} !== {1'b1, 4'd7, 32'h22}) begin errors++; $display("FAIL same_w1 got we=%b a3=%0d wd3=%0h want 1 7 22", WE3, A3, WD3); end
    tick(); REQ_VALID = 2'b00;
    @(negedge CLK);
    checks++; if ({WE3, A3, WD3} !== {1'b1, 4'd7, 32'h11}) begin errors++; $display("FAIL same_w2 got we=%b a3=%0d wd3=%0h want 1 7 11", WE3, A3, WD3); end
    tick();
    @(negedge CLK);
    checks++; if (bank_rd(7) !== 32'h11 || bank_rd(3) !== 32'h33) begin errors++; $display("FAIL same_bank got r7=%0h r3=%0h want 11 33", bank_rd(7), bank_rd(3)); end
    tick();
  endtask

  task automatic test_ro();
    logic [3:0] addrs [2];
    addrs[0] = 4'd0; addrs[1] = 4'd15;
    for (int n = 0; n < 2; n++) begin
      REQ_ADDR = {4'd0, addrs[n]}; REQ_DATA = {32'h0, 32'hDEAD0 + 32'(n)}; REQ_VALID = 2'b01;
      @(negedge CLK);
      checks++; if (REQ_READY !== 2'b01) begin errors++; $display("FAIL ro_ready[%0d] got %b want 01", n, REQ_READY); end
      tick(); REQ_VALID = 2'b00;
      @(negedge CLK);
      checks++; if ({WE3, RO_ERR, A3, WD3} !== {1'b0, 1'b1, addrs[n], 32'hDEAD0 + 32'(n)}) begin errors++; $display("FAIL ro_flag[%0d] got we=%b ro=%b a3=%0d wd3=%0h want 0 1 %0d %0h", n, WE3, RO_ERR, A3, WD3, addrs[n], 32'hDEAD0 + 32'(n)); end
      tick();
      @(negedge CLK);
      checks++; if (RO_ERR !== 1'b0) begin errors++; $display("FAIL ro_pulse[%0d] got %b want 0", n, RO_ERR); end
    end
    checks++; if (bank_rd(0) !== 32'd65536 || bank_rd(15) !== 32'd81928) begin errors++; $display("FAIL ro_bank got r0=%0d r15=%0d want 65536 81928", bank_rd(0), bank_rd(15)); end
    tick();
  endtask

  task automatic test_freeze();
    // Per cycle: FREEZE, expected READY, expected WE3, expected WD3 (when WE3).
    logic       frz  [8];
    logic [1:0] rdy  [8];
    logic       we   [8];
    logic [31:0] wd  [8];
    logic [31:0] d;
    frz = '{0, 1, 1, 1, 0, 0, 0, 0};
    rdy = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    we  = '{0, 1, 0, 0, 0, 1, 1, 0};
    wd  = '{0, 32'h500, 0, 0, 0, 32'h501, 32'h502, 0};
    d = 32'h500;
    REQ_ADDR = {4'd0, 4'd8}; REQ_DATA = {32'h0, d}; REQ_VALID = 2'b01;
    for (int c = 0; c < 8; c++) begin
      FREEZE = frz[c];
      @(negedge CLK);
      checks++; if (REQ_READY !== rdy[c]) begin errors++; $display("FAIL frz_ready[%0d] got %b want %b", c, REQ_READY, rdy[c]); end
      checks++; if (WE3 !== we[c] || (we[c] && WD3 !== wd[c])) begin errors++; $display("FAIL frz_out[%0d] got we=%b wd3=%0h want we=%b wd3=%0h", c, WE3, WD3, we[c], wd[c]); end
      tick();
      if (rdy[c] == 2'b01) begin
        d = d + 32'h1;
        REQ_DATA = {32'h0, d};
        if (d == 32'h503) REQ_VALID = 2'b00;
      end
    end
    FREEZE = 1'b0;
    checks++; if (bank_rd(8) !== 32'h502) begin errors++; $display("FAIL frz_bank got %0h want 502", bank_rd(8)); end
  endtask

  task automatic test_reset_mid();
    REQ_ADDR = {4'd0, 4'd9}; REQ_DATA = {32'h0, 32'h99}; REQ_VALID = 2'b01;
    @(negedge CLK);
    checks++; if (REQ_READY !== 2'b01) begin errors++; $display("FAIL rmid_ready got %b want 01", REQ_READY); end
    tick();
    RST = 1'b1; REQ_DATA = {32'h0, 32'h9A};
    @(negedge CLK);
    checks++; if (REQ_READY !== 2'b00 || WE3 !== 1'b1) begin errors++; $display("FAIL rmid_inrst got ready=%b we=%b want 00 1", REQ_READY, WE3); end
    tick();
    RST = 1'b0; REQ_VALID = 2'b00;
    @(negedge CLK);
    checks++; if ({WE3, A3, WD3, LAST_GRANT, RO_ERR} !== '0) begin errors++; $display("FAIL rmid_cleared got we=%b a3=%0d wd3=%0h lg=%0d ro=%b want 0", WE3, A3, WD3, LAST_GRANT, RO_ERR); end
    checks++; if (bank_rd(9) !== 32'h99) begin errors++; $display("FAIL rmid_bank got %0h want 99", bank_rd(9)); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_same_addr();
    test_ro();
    test_freeze();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regbank_write_arbiter.md
# regbank_write_arbiter

Round-robin arbiter that shares the single write port (WE3/A3/WD3) of the 16×32 register bank between up to four writeback sources, such as the ALU, the load unit and the vector lanes. Each source presents a valid/ready write request. The arbiter grants at most one request per cycle, registers the winning write, and drives the bank write port one cycle later. It also filters writes to the bank's two read-only constant registers (0 and 15) and flags them.

## Interface
- N_REQ, default 2, number of requesters (legal range 2..4)
- DATA_W, default 32, write data width
- ADDR_W, default 4, register address width
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- FREEZE  in  1  pipeline hold; when high, no grants are issued
- REQ_VALID  in  N_REQ  per-requester write request
- REQ_ADDR  in  N_REQ*ADDR_W  packed destination addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
- REQ_DATA  in  N_REQ*DATA_W  packed write data, packed the same way
- REQ_READY  out  N_REQ  grant; combinational, at most one bit high
- WE3  out  1  bank write enable, registered
- A3  out  ADDR_W  bank write address, registered
- WD3  out  DATA_W  bank write data, registered
- RO_ERR  out  1  one-cycle pulse: an accepted write targeted register 0 or 15
- LAST_GRANT  out  2  index of the most recently accepted requester, registered

## Operation
- Round-robin pointer PTR (2 bits, range 0..N_REQ-1) holds the highest-priority requester.
- Grant rule:
  - Scan i = PTR, PTR+1, … mod N_REQ.
  - The first i with REQ_VALID[i]=1 gets REQ_READY[i]=1.
  - If FREEZE=1 or RST=1, all REQ_READY bits are 0.
- A handshake fires on REQ_VALID[i] & REQ_READY[i]. On fire:
  - PTR <= (i+1) mod N_REQ.
  - LAST_GRANT <= i.
  - The output stage captures REQ_ADDR[i] and REQ_DATA[i].
- When no handshake fires, PTR and LAST_GRANT hold their values.
- Output stage, next edge after a fire:
  - Normal address: WE3=1, A3=addr, WD3=data.
  - Address 0 or 15: WE3=0, RO_ERR=1, A3/WD3 still loaded. The request is consumed, not retried.
- Output stage, next edge with no fire: WE3=0, RO_ERR=0, A3/WD3 hold their values.
- Requester protocol:
  - REQ_VALID must not depend on REQ_READY.
  - Once asserted, VALID, ADDR and DATA stay stable until the handshake fires.
  - The arbiter does not check this; violations give undefined ordering.
- Ordering:
  - Writes from one requester reach the bank in acceptance order.
  - Same-address writes from different requesters reach the bank in grant order. The later grant wins.
- Starvation bound: a continuously valid requester is granted within N_REQ non-frozen cycles.

## Timing
- Reset values: PTR=0, LAST_GRANT=0, WE3=0, A3=0, WD3=0, RO_ERR=0. REQ_READY is all-zero while RST=1.
- Reset mid-operation:
  - A write captured in the output stage on the edge where RST=1 is discarded; WE3 is 0 the next cycle.
  - A request asserted during reset is not accepted.
- Latency:
  - Request accepted at edge k.
  - WE3/A3/WD3 valid during cycle k+1.
  - Bank updated at edge k+1.
- Throughput: one write per cycle while any request is valid and FREEZE=0.
- FREEZE:
  - Takes effect combinationally on REQ_READY in the same cycle.
  - The write already in the output stage still completes; WE3 drops the cycle after the first frozen edge.
- No read bypass is provided; a read of A3 during cycle k+1 returns the old value.

## Test plan
- Reset with REQ_VALID=2'b11 held → REQ_READY=00, WE3=0 throughout reset. First cycle after reset: REQ_READY=01 (PTR=0).
- Single requester 1 writes addr 5, data 0x0000_00AA → REQ_READY[1]=1 at cycle k. Cycle k+1: WE3=1, A3=5, WD3=0xAA. Reading A1=5 afterwards returns 0xAA.
- Both requesters continuously valid for 6 cycles with distinct addresses → grants alternate 0,1,0,1,0,1; LAST_GRANT follows one cycle later; WE3=1 for 6 consecutive cycles.
- Both write addr 7 in the same cycle (req0: 0x11, req1: 0x22), PTR=1 → req1 granted first, req0 next. Final bank value of reg 7 = 0x11.
- Requester 0 writes addr 0, later addr 15 → each is accepted with WE3=0 and RO_ERR=1 for one cycle. Reads of reg 0 and reg 15 still return 65536 and 81928.
- Requester 0 streaming; raise FREEZE for 3 cycles → REQ_READY=0 for those cycles, WE3=0 after the in-flight write. Streaming resumes from the held request with no lost or duplicated writes.
